// File: rtl/cpu_ctrl_pkg.sv
// Shared constants and types for the multicycle processor control path.
package cpu_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_HALT    = 4'd12
  } state_e;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU control decode: fixed add/sub from the FSM, or the R-type Funct field.
module alu_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [1:0] aluop_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_control_o
);

  // Unknown Funct values fall back to add rather than flagging an error.
  always_comb begin
    alu_control_o = ALU_ADD;
    if (aluop_i == ALUOP_SUB) begin
      alu_control_o = ALU_SUB;
    end else if (aluop_i == ALUOP_FUNCT) begin
      unique case (funct_i)
        FUNCT_ADD: alu_control_o = ALU_ADD;
        FUNCT_SUB: alu_control_o = ALU_SUB;
        FUNCT_AND: alu_control_o = ALU_AND;
        FUNCT_OR:  alu_control_o = ALU_OR;
        FUNCT_SLT: alu_control_o = ALU_SLT;
        default:   alu_control_o = ALU_ADD;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle control FSM: sequences fetch/decode/execute over one shared memory port.
module multicycle_controller
  import cpu_ctrl_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       MemWrite,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCEn,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       AluSrcA,
  output logic [1:0] AluSrcB,
  output logic [1:0] PCSrc,
  output logic [2:0] AluControl,
  output logic       Illegal
);

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   irwrite, pcwrite, branch, regwrite;
  aluop_e aluop;

  // State and sticky illegal-opcode flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state and Moore output decode; MemReady only matters in request states.
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    MemReq    = 1'b0;
    MemWrite  = 1'b0;
    IorD      = 1'b0;
    irwrite   = 1'b0;
    pcwrite   = 1'b0;
    branch    = 1'b0;
    regwrite  = 1'b0;
    RegDst    = 1'b0;
    MemtoReg  = 1'b0;
    AluSrcA   = 1'b0;
    AluSrcB   = 2'b00;
    PCSrc     = 2'b00;
    aluop     = ALUOP_ADD;
    unique case (state_q)
      S_FETCH: begin
        MemReq  = 1'b1;
        AluSrcB = 2'b01;
        if (MemReady) begin
          irwrite = 1'b1;
          pcwrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        AluSrcB = 2'b11;
        unique case (Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            illegal_d = 1'b1;
            state_d   = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        AluSrcA = 1'b1;
        AluSrcB = 2'b10;
        state_d = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        MemReq = 1'b1;
        IorD   = 1'b1;
        if (MemReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        MemtoReg = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        MemReq   = 1'b1;
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (MemReady) state_d = S_FETCH;
      end
      S_EXECUTE: begin
        AluSrcA = 1'b1;
        aluop   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        RegDst   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        AluSrcA = 1'b1;
        aluop   = ALUOP_SUB;
        PCSrc   = 2'b01;
        branch  = 1'b1;
        state_d = S_FETCH;
      end
      S_ADDIEX: begin
        AluSrcA = 1'b1;
        AluSrcB = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        PCSrc   = 2'b10;
        pcwrite = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // While reset is held the state reads FETCH, so enables are masked to keep
  // a concurrent MemReady from loading the IR or PC.
  assign IRWrite  = irwrite & ~reset;
  assign PCEn     = (pcwrite | (branch & Zero)) & ~reset;
  assign RegWrite = regwrite & ~reset;
  assign Illegal  = illegal_q;

  alu_decoder u_alu_decoder (
    .aluop_i       (aluop),
    .funct_i       (Funct),
    .alu_control_o (AluControl)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-instruction expected cycle recipes.
module tb_multicycle_controller;

  typedef struct packed {
    logic       memreq, memwrite, iord, irwrite, pcen, regwrite, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] aluctl;
    logic       illegal;
  } outv_t;

  typedef struct {
    outv_t e;
    outv_t m;
    logic  rdy;
    logic  z;
  } step_t;

  logic        clk = 1'b0;
  logic        rst1, rst0;
  logic [5:0]  Op, Funct;
  logic        Zero, MemReady;
  logic [16:0] o1, o0;
  logic        sel;
  outv_t       act;
  int          checks = 0;
  int          errors = 0;
  logic        ill;
  step_t       q[$];

  always #5 clk = ~clk;

  multicycle_controller #(.HALT_ON_ILLEGAL(1'b1)) dut1 (
    .clk(clk), .reset(rst1), .Op(Op), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
    .MemReq(o1[16]), .MemWrite(o1[15]), .IorD(o1[14]), .IRWrite(o1[13]), .PCEn(o1[12]),
    .RegWrite(o1[11]), .RegDst(o1[10]), .MemtoReg(o1[9]), .AluSrcA(o1[8]),
    .AluSrcB(o1[7:6]), .PCSrc(o1[5:4]), .AluControl(o1[3:1]), .Illegal(o1[0])
  );

  multicycle_controller #(.HALT_ON_ILLEGAL(1'b0)) dut0 (
    .clk(clk), .reset(rst0), .Op(Op), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
    .MemReq(o0[16]), .MemWrite(o0[15]), .IorD(o0[14]), .IRWrite(o0[13]), .PCEn(o0[12]),
    .RegWrite(o0[11]), .RegDst(o0[10]), .MemtoReg(o0[9]), .AluSrcA(o0[8]),
    .AluSrcB(o0[7:6]), .PCSrc(o0[5:4]), .AluControl(o0[3:1]), .Illegal(o0[0])
  );

  always_comb act = sel ? outv_t'(o1) : outv_t'(o0);

  // ---------------- model: per-cycle expectations from the instruction recipes
  function automatic logic [2:0] alu_of(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic step_t base(input logic rdy, input logic z, input logic il);
    step_t s;
    s.e = '0; s.m = '0;
    s.m.memreq = 1'b1; s.m.memwrite = 1'b1; s.m.irwrite = 1'b1;
    s.m.pcen = 1'b1; s.m.regwrite = 1'b1; s.m.illegal = 1'b1;
    s.e.illegal = il; s.rdy = rdy; s.z = z;
    return s;
  endfunction

  function automatic step_t alu_step(input step_t s0, input logic a, input logic [1:0] b,
                                     input logic [2:0] ctl);
    step_t s = s0;
    s.e.alusrca = a;   s.m.alusrca = 1'b1;
    s.e.alusrcb = b;   s.m.alusrcb = 2'b11;
    s.e.aluctl  = ctl; s.m.aluctl  = 3'b111;
    return s;
  endfunction

  function automatic step_t fetch_s(input logic rdy, input logic il);
    step_t s = alu_step(base(rdy, 1'b0, il), 1'b0, 2'b01, 3'b010);
    s.e.memreq = 1'b1; s.m.iord = 1'b1; s.m.pcsrc = 2'b11;
    s.e.irwrite = rdy; s.e.pcen = rdy;
    return s;
  endfunction

  function automatic step_t wb_s(input logic dst, input logic m2r);
    step_t s = base(1'b0, 1'b0, ill);
    s.e.regwrite = 1'b1;
    s.e.regdst = dst;   s.m.regdst = 1'b1;
    s.e.memtoreg = m2r; s.m.memtoreg = 1'b1;
    return s;
  endfunction

  function automatic step_t mem_s(input logic rdy, input logic wr);
    step_t s = base(rdy, 1'b0, ill);
    s.e.memreq = 1'b1; s.e.memwrite = wr; s.e.iord = 1'b1; s.m.iord = 1'b1;
    return s;
  endfunction

  task automatic prog(input logic [5:0] op, input logic [5:0] f, input logic z,
                      input int fw, input int mw, input logic halt_param);
    step_t s;
    for (int i = 0; i < fw; i++) q.push_back(fetch_s(1'b0, ill));
    q.push_back(fetch_s(1'b1, ill));
    q.push_back(alu_step(base(1'b0, 1'b0, ill), 1'b0, 2'b11, 3'b010));
    case (op)
      6'b100011, 6'b101011: begin
        q.push_back(alu_step(base(1'b0, 1'b0, ill), 1'b1, 2'b10, 3'b010));
        for (int i = 0; i < mw; i++) q.push_back(mem_s(1'b0, op == 6'b101011));
        q.push_back(mem_s(1'b1, op == 6'b101011));
        if (op == 6'b100011) q.push_back(wb_s(1'b0, 1'b1));
      end
      6'b000000: begin
        q.push_back(alu_step(base(1'b0, 1'b0, ill), 1'b1, 2'b00, alu_of(f)));
        q.push_back(wb_s(1'b1, 1'b0));
      end
      6'b000100: begin
        s = alu_step(base(1'b0, z, ill), 1'b1, 2'b00, 3'b110);
        s.e.pcsrc = 2'b01; s.m.pcsrc = 2'b11; s.e.pcen = z;
        q.push_back(s);
      end
      6'b001000: begin
        q.push_back(alu_step(base(1'b0, 1'b0, ill), 1'b1, 2'b10, 3'b010));
        q.push_back(wb_s(1'b0, 1'b0));
      end
      6'b000010: begin
        s = base(1'b0, 1'b0, ill);
        s.e.pcsrc = 2'b10; s.m.pcsrc = 2'b11; s.e.pcen = 1'b1;
        q.push_back(s);
      end
      default: begin
        ill = 1'b1;
        if (halt_param)
          for (int i = 0; i < 20; i++) q.push_back(base(1'b1, 1'b0, 1'b1));
      end
    endcase
  endtask

  // ---------------- comparison
  task automatic cmp(input string name, input outv_t e, input outv_t m);
    checks++;
    if (((act ^ e) & m) != '0) begin
      errors++;
      $display("FAIL %s: got %b, want %b (mask %b) at %0t", name, act, e, m, $time);
    end
  endtask

  task automatic lit(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic fetch_sig();
    return act.memreq && !act.iord && act.alusrcb == 2'b01 && !act.alusrca;
  endfunction

  // Drive the queued cycles, comparing each; latency is measured from the DUT:
  // cycles from the completing fetch until fetch outputs reappear.
  task automatic exec_q(input string name, input int lat_exp);
    int lat = 0;
    bit started = 0, ended = 0;
    step_t s;
    while (q.size() > 0) begin
      s = q.pop_front();
      MemReady = s.rdy; Zero = s.z;
      @(negedge clk);
      cmp(name, s.e, s.m);
      if (!started) begin
        if (fetch_sig() && act.irwrite) begin started = 1; lat = 1; end
      end else if (!ended) begin
        if (fetch_sig()) ended = 1; else lat++;
      end
      @(posedge clk); #1;
    end
    MemReady = 1'b0;
    @(negedge clk);
    if (started && !ended && !fetch_sig()) lat++;
    if (lat_exp > 0) lit({name, "_latency"}, lat, lat_exp);
    @(posedge clk); #1;
  endtask

  step_t s;

  initial begin
    sel = 1'b1; ill = 1'b0;
    rst1 = 1'b1; rst0 = 1'b1;
    Op = '0; Funct = '0; Zero = 1'b0; MemReady = 1'b1;
    #2;
    // Reset state: fetch outputs, enables masked despite MemReady.
    lit("rst_memreq", int'(act.memreq), 1);
    lit("rst_alusrcb", int'(act.alusrcb), 1);
    lit("rst_aluctl", int'(act.aluctl), 3'b010);
    lit("rst_irwrite", int'(act.irwrite), 0);
    cmp("rst_state", fetch_s(1'b0, 1'b0).e, fetch_s(1'b0, 1'b0).m);
    @(negedge clk); rst1 = 1'b0; MemReady = 1'b0;
    @(posedge clk); #1;

    Op = 6'b100011; prog(Op, 6'd0, 1'b0, 0, 0, 1'b1); exec_q("lw", 5);
    Op = 6'b000000; Funct = 6'b100010; prog(Op, Funct, 1'b0, 0, 0, 1'b1); exec_q("rsub", 4);
    Funct = 6'b100100; prog(Op, Funct, 1'b0, 1, 0, 1'b1); exec_q("rand", 4);
    Funct = 6'b100101; prog(Op, Funct, 1'b0, 0, 0, 1'b1); exec_q("ror", 4);
    Funct = 6'b101010; prog(Op, Funct, 1'b0, 0, 0, 1'b1); exec_q("rslt", 4);
    Funct = 6'b111000; prog(Op, Funct, 1'b0, 0, 0, 1'b1); exec_q("rbad", 4);
    Op = 6'b000100; prog(Op, 6'd0, 1'b1, 0, 0, 1'b1); exec_q("beq_t", 3);
    prog(Op, 6'd0, 1'b0, 0, 0, 1'b1); exec_q("beq_nt", 3);
    Op = 6'b101011; prog(Op, 6'd0, 1'b0, 0, 3, 1'b1); exec_q("sw_wait", 7);
    Op = 6'b001000; prog(Op, 6'd0, 1'b0, 0, 0, 1'b1); exec_q("addi", 4);
    Op = 6'b000010; prog(Op, 6'd0, 1'b0, 0, 0, 1'b1); exec_q("j", 3);
    Op = 6'b100011; prog(Op, 6'd0, 1'b0, 2, 2, 1'b1); exec_q("lw_wait", 7);

    // Reset while waiting in MEMRD with MemReady arriving during reset.
    Op = 6'b100011;
    q.push_back(fetch_s(1'b1, ill));
    q.push_back(alu_step(base(1'b0, 1'b0, ill), 1'b0, 2'b11, 3'b010));
    q.push_back(alu_step(base(1'b0, 1'b0, ill), 1'b1, 2'b10, 3'b010));
    while (q.size() > 0) begin
      s = q.pop_front(); MemReady = s.rdy; Zero = s.z;
      @(negedge clk); cmp("lw_pre", s.e, s.m);
      @(posedge clk); #1;
    end
    MemReady = 1'b0; #1;
    cmp("memrd_wait", mem_s(1'b0, 1'b0).e, mem_s(1'b0, 1'b0).m);
    #1; rst1 = 1'b1; MemReady = 1'b1; #1;
    cmp("rst_midwait", fetch_s(1'b0, 1'b0).e, fetch_s(1'b0, 1'b0).m);
    @(negedge clk);
    cmp("rst_held", fetch_s(1'b0, 1'b0).e, fetch_s(1'b0, 1'b0).m);
    rst1 = 1'b0; MemReady = 1'b0;
    @(posedge clk); #1;
    prog(Op, 6'd0, 1'b0, 0, 0, 1'b1); exec_q("lw_after_rst", 5);

    // Illegal opcode, halting variant.
    Op = 6'b111111; prog(Op, 6'd0, 1'b0, 0, 0, 1'b1); exec_q("illegal_halt", 0);
    lit("halt_illegal", int'(act.illegal), 1);
    lit("halt_memreq", int'(act.memreq), 0);
    rst1 = 1'b1; ill = 1'b0; #1;
    lit("halt_rst_illegal", int'(act.illegal), 0);
    cmp("halt_rst", fetch_s(1'b0, 1'b0).e, fetch_s(1'b0, 1'b0).m);
    @(negedge clk); rst1 = 1'b0;
    @(posedge clk); #1;
    Op = 6'b001000; prog(Op, 6'd0, 1'b0, 0, 0, 1'b1); exec_q("addi_after_halt", 4);

    // Illegal opcode, retire-as-NOP variant.
    sel = 1'b0; ill = 1'b0;
    @(negedge clk); rst0 = 1'b0;
    @(posedge clk); #1;
    Op = 6'b111111; prog(Op, 6'd0, 1'b0, 0, 0, 1'b0); exec_q("illegal_nop", 2);
    lit("nop_illegal", int'(act.illegal), 1);
    Op = 6'b001000; prog(Op, 6'd0, 1'b0, 0, 0, 1'b0); exec_q("addi_sticky", 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
